// File: rtl/alu_seq_ctrl_if.sv
// Front-end request/response bundle for alu_seq_ctrl.
//   master : instruction front end (drives req_*, receives rsp_* / jump_*)
//   slave  : sequencer (receives req_*, drives req_ready, rsp_* / jump_*)
// Signals:
//   req_valid/req_ready  handshake, one op accepted per transfer
//   req_op/req_mode      opcode and full(1)/half(0) word select
//   req_a/req_b          operands; req_a doubles as jump target and LSR/XSR value
//   rsp_valid            one-cycle pulse qualifying rsp_c/rsp_c2/jump_*
//   rsp_c/rsp_c2         masked ALU results
//   jump_taken/target    flow-op resolution
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 20,
    parameter int OPW   = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [OPW-1:0]   req_op;
    logic             req_mode;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_c;
    logic [WIDTH-1:0] rsp_c2;
    logic             jump_taken;
    logic [WIDTH-1:0] jump_target;

    modport master (
        output req_valid, req_op, req_mode, req_a, req_b,
        input  req_ready, rsp_valid, rsp_c, rsp_c2, jump_taken, jump_target
    );

    modport slave (
        input  req_valid, req_op, req_mode, req_a, req_b,
        output req_ready, rsp_valid, rsp_c, rsp_c2, jump_taken, jump_target
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer between the instruction front end and a combinational ALU.
// Accepts one op per handshake, drives the ALU from registered operands,
// captures the result, maintains the {C,S,Z} status register, resolves
// flow ops and parks in TRAP until trap_clr.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   bus (slave)       request/response bundle, see alu_seq_ctrl_if
//   alu_op/mode/a/b   registered op and operands to the ALU
//   alu_cin           status C, carry-in for ADC/SBC
//   alu_c/alu_c2      ALU results
//   alu_zero/sign/carry  ALU flags
//   status            {C,S,Z}
//   trap, trap_clr    trap indication / release
//
// state | meaning
// ------+-----------------------------------------------------
// IDLE  | req_ready=1, waiting for a request
// EXEC  | ALU inputs stable; result and status captured at edge
// WB    | rsp_valid pulse; trap ops/illegal head to TRAP
// TRAP  | trap=1, wait for trap_clr
module alu_seq_ctrl #(
    parameter int WIDTH = 20,
    parameter int HALF  = 10,
    parameter int OPW   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_ctrl_if.slave     bus,
    output logic [OPW-1:0]    alu_op,
    output logic              alu_mode,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_cin,
    input  logic [WIDTH-1:0]  alu_c,
    input  logic [WIDTH-1:0]  alu_c2,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic              alu_carry,
    output logic [2:0]        status,
    output logic              trap,
    input  logic              trap_clr
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_TRAP} state_t;

    localparam logic [OPW-1:0] OP_TRAP = OPW'(0);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(2);
    localparam logic [OPW-1:0] OP_JZ   = OPW'(3);
    localparam logic [OPW-1:0] OP_JS   = OPW'(4);
    localparam logic [OPW-1:0] OP_JZS  = OPW'(5);
    localparam logic [OPW-1:0] OP_LSR  = OPW'(6);
    localparam logic [OPW-1:0] OP_XSR  = OPW'(7);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(8);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(11);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(12);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(13);
    localparam logic [OPW-1:0] OP_INC  = OPW'(17);
    localparam logic [OPW-1:0] OP_SBC  = OPW'(22);
    localparam logic [OPW-1:0] OP_EQ   = OPW'(23);
    localparam logic [OPW-1:0] OP_LE   = OPW'(27);
    localparam logic [OPW-1:0] OP_ILL  = OPW'(28);

    localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

    state_t           state_q, state_d;
    logic [OPW-1:0]   op_q;
    logic             mode_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] c_q, c2_q;
    logic             jump_q, jump_d;
    logic [2:0]       status_q, status_d;
    logic [WIDTH-1:0] res_mask;
    logic             accept;
    logic             op_is_trap;

    assign accept     = bus.req_valid && (state_q == S_IDLE);
    assign op_is_trap = (op_q == OP_TRAP) || (op_q >= OP_ILL);
    assign res_mask   = mode_q ? {WIDTH{1'b1}} : HALF_MASK;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.req_valid) state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = op_is_trap ? S_TRAP : S_IDLE;
            S_TRAP: if (trap_clr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.rsp_valid = (state_q == S_WB);
        trap          = (state_q == S_TRAP);
    end

    // Status update; flags the op class does not touch keep their value.
    // status = {C,S,Z}
    always_comb begin
        status_d = status_q;
        if (op_q >= OP_NOT && op_q <= OP_XOR) begin
            status_d[0] = alu_zero;
        end else if (op_q == OP_SHR || op_q == OP_SHL) begin
            status_d[0] = alu_zero;
            status_d[2] = alu_carry;
        end else if (op_q >= OP_INC && op_q <= OP_SBC) begin
            status_d = {alu_carry, alu_sign, alu_zero};
        end else if (op_q >= OP_EQ && op_q <= OP_LE) begin
            status_d[0] = alu_zero;
            status_d[1] = alu_sign;
        end else if (op_q == OP_LSR) begin
            status_d = a_q[2:0];
        end else if (op_q == OP_XSR) begin
            status_d = status_q ^ a_q[2:0];
        end
    end

    // Jumps look at status_q, i.e. the flags left by the previous op.
    always_comb begin
        case (op_q)
            OP_JMP:  jump_d = 1'b1;
            OP_JZ:   jump_d = status_q[0];
            OP_JS:   jump_d = status_q[1];
            OP_JZS:  jump_d = status_q[0] | status_q[1];
            default: jump_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            c2_q     <= '0;
            jump_q   <= 1'b0;
            status_q <= 3'b000;
        end else begin
            if (accept) begin
                op_q   <= bus.req_op;
                mode_q <= bus.req_mode;
                a_q    <= bus.req_a;
                b_q    <= bus.req_b;
            end
            if (state_q == S_EXEC) begin
                c_q      <= alu_c & res_mask;
                c2_q     <= alu_c2 & res_mask;
                jump_q   <= jump_d;
                status_q <= status_d;
            end
        end
    end

    assign alu_op          = op_q;
    assign alu_mode        = mode_q;
    assign alu_a           = a_q;
    assign alu_b           = b_q;
    assign alu_cin         = status_q[2];
    assign status          = status_q;
    assign bus.rsp_c       = c_q;
    assign bus.rsp_c2      = c2_q;
    assign bus.jump_taken  = jump_q;
    assign bus.jump_target = a_q;

endmodule
